phys_mem_responder: RTL and testbench

PHYS_MEM_RESPONDER -- requirements
Module: phys_mem_responder

---
 rtl/phys_mem_responder_if.sv | 20 ++
 rtl/phys_mem_responder.sv | 143 ++++++++++++++
 tb/tb_phys_mem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/phys_mem_responder_if.sv
// Request/response handshake between a translated-address requester and phys_mem_responder.
// The 32-bit bidirectional data bus is a resolved net and is connected as a separate port.
interface phys_mem_if;
    logic [47:0] address;
    logic        device_space;
    logic        mem_read;
    logic        mem_write;
    logic        mem_valid;
    logic        bus_error;

    modport master (
        output address, device_space, mem_read, mem_write,
        input  mem_valid, bus_error
    );

    modport slave (
        input  address, device_space, mem_read, mem_write,
        output mem_valid, bus_error
    );
endinterface

// File: rtl/phys_mem_responder.sv
// Fixed-latency responder for a word RAM and a four-word device register bank.
// Define PHYS_MEM_ACCESS_COUNT_EN to turn device word 0xC into a completed-access counter.
module phys_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    phys_mem_if.slave   bus,
    inout  wire  [31:0] io_mem_data
);
    localparam logic [31:0] DEV_ID = 32'h564C5749;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_cycle;
    logic [31:0] r_scratch;
`ifdef PHYS_MEM_ACCESS_COUNT_EN
    logic [31:0] r_acc_cnt;
`endif

    logic [47:2] r_addr;
    logic        r_dev;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_ram_oob;
    logic                  w_dev_oob;
    logic                  w_err;
    logic                  w_wr_ok;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_reg;
    logic [31:0]           w_rdata;
    logic [1:0]            w_unused_addr;

    assign w_req         = bus.mem_read | bus.mem_write;
    assign w_accept      = (r_state == ST_IDLE) & w_req;
    assign w_done        = (r_state == ST_DONE);
    assign w_unused_addr = bus.address[1:0];

    // The accept cycle counts as the first latency cycle, so WAIT lasts LATENCY-1 cycles.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next_state = (LATENCY == 1) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (r_cnt <= 4'd1) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept)
                r_cnt <= 4'(LATENCY - 1);
            else if (r_state == ST_WAIT)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr  <= bus.address[47:2];
            r_dev   <= bus.device_space;
            r_rd    <= bus.mem_read;
            r_wr    <= bus.mem_write;
            r_wdata <= io_mem_data;
        end
    end

    assign w_idx     = r_addr[DEPTH_LOG2+1:2];
    assign w_reg     = r_addr[3:2];
    assign w_ram_oob = |(r_addr >> DEPTH_LOG2);
    assign w_dev_oob = |r_addr[47:4];
    assign w_err     = (r_rd & r_wr) | (r_dev ? w_dev_oob : w_ram_oob);
    assign w_wr_ok   = w_done & r_wr & ~w_err;

    always_comb begin
        w_rdata = '0;
        if (r_rd && !w_err) begin
            if (r_dev) begin
                case (w_reg)
                    2'd0:    w_rdata = DEV_ID;
                    2'd1:    w_rdata = r_scratch;
                    2'd2:    w_rdata = r_cycle;
                    default: begin
`ifdef PHYS_MEM_ACCESS_COUNT_EN
                        w_rdata = r_acc_cnt;
`else
                        w_rdata = '0;
`endif
                    end
                endcase
            end else begin
                w_rdata = r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_ok && !r_dev)
            r_mem[w_idx] <= r_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle   <= '0;
            r_scratch <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_ok && r_dev && (w_reg == 2'd1))
                r_scratch <= r_wdata;
        end
    end

`ifdef PHYS_MEM_ACCESS_COUNT_EN
    // A write to 0xC clears the count, taking priority over counting its own completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_acc_cnt <= '0;
        else if (w_wr_ok && r_dev && (w_reg == 2'd3))
            r_acc_cnt <= '0;
        else if (w_done)
            r_acc_cnt <= r_acc_cnt + 32'd1;
    end
`endif

    assign bus.mem_valid = w_done;
    assign bus.bus_error = w_done & w_err;
    assign io_mem_data   = bus.mem_read ? (w_done ? w_rdata : 32'd0) : 'z;
endmodule

// File: tb/tb_phys_mem_responder.sv
// Directed and randomized bench for phys_mem_responder against a behavioural model of RAM and device bank.
module tb_phys_mem_responder;
    localparam int          DL2       = 13;
    localparam int          LAT       = 2;
    localparam longint      RAM_BYTES = 64'd4 << DL2;
    localparam logic [31:0] DEV_ID    = 32'h564C5749;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        drv_en  = 1'b0;
    logic [31:0] drv_val = '0;
    wire  [31:0] mem_data;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc;
    logic [31:0] ram_m [int];
    logic [31:0] scratch_m = '0;
    logic [31:0] acc_m     = '0;
    logic [31:0] got;
    logic [31:0] v1;
    logic        last_acc;

    phys_mem_if bus ();

    assign mem_data = drv_en ? drv_val : 'z;

    phys_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus),
        .io_mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Reference time base: rising edges seen since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one completed access; updates the model state.
    task automatic model(input logic rd, input logic wr, input logic dev,
                         input logic [47:0] a, input logic [31:0] wd,
                         output logic [31:0] ed, output logic ee, output logic known);
        int off;
`ifdef PHYS_MEM_ACCESS_COUNT_EN
        logic clr;
        clr = 1'b0;
`endif
        ed = '0; ee = 1'b0; known = 1'b1;
        if (rd && wr) begin
            ee = 1'b1;
        end else if (!dev) begin
            if (longint'(a) >= RAM_BYTES) ee = 1'b1;
            else if (wr) ram_m[int'(a / 4)] = wd;
            else if (ram_m.exists(int'(a / 4))) ed = ram_m[int'(a / 4)];
            else known = 1'b0;
        end else if (a > 48'd15) begin
            ee = 1'b1;
        end else begin
            off = int'(a) / 4;
            case (off)
                0: ed = DEV_ID;
                1: if (wr) scratch_m = wd; else ed = scratch_m;
                2: ed = cyc;
                default: begin
`ifdef PHYS_MEM_ACCESS_COUNT_EN
                    ed  = acc_m;
                    clr = wr;
`endif
                end
            endcase
        end
`ifdef PHYS_MEM_ACCESS_COUNT_EN
        acc_m = clr ? 32'd0 : acc_m + 32'd1;
`endif
    endtask

    task automatic access(input logic rd, input logic wr, input logic dev,
                          input logic [47:0] a, input logic [31:0] wd,
                          input int exp_lat, input string tag, output logic [31:0] rdat);
        logic [31:0] ed;
        logic ee, known, seen;
        int n;
        bus.address = a; bus.device_space = dev;
        bus.mem_read = rd; bus.mem_write = wr;
        drv_en = wr & ~rd; drv_val = wd;
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = bus.mem_valid;
            if (!seen) chk({tag, "/err_idle"}, 48'(bus.bus_error), 48'd0);
        end
        rdat = mem_data;
        chk({tag, "/valid"}, 48'(seen), 48'd1);
        if (seen) begin
            model(rd, wr, dev, a, wd, ed, ee, known);
            if (exp_lat > 0) chk({tag, "/latency"}, 48'(n), 48'(exp_lat));
            chk({tag, "/bus_error"}, 48'(bus.bus_error), 48'(ee));
            if (rd && known) chk({tag, "/rdata"}, 48'(rdat), 48'(ed));
        end
    endtask

    task automatic idle();
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; drv_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.address = '0; bus.device_space = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/mem_valid", 48'(bus.mem_valid), 48'd0);
        chk("reset/bus_error", 48'(bus.bus_error), 48'd0);
        rst_n = 1'b1;

        // RAM write then read, first request right after reset release
        access(0, 1, 0, 48'h4000, 32'hDEADBEEF, LAT, "w4000", got); idle();
        access(1, 0, 0, 48'h4000, 32'h0, LAT, "r4000", got); idle();
        chk("r4000/const", 48'(got), 48'hDEADBEEF);

        // Back-to-back reads with mem_read held
        access(0, 1, 0, 48'h0, 32'h11111111, LAT, "w0", got); idle();
        access(0, 1, 0, 48'h4, 32'h22222222, LAT, "w4", got); idle();
        access(1, 0, 0, 48'h0, 32'h0, LAT, "b2b0", got);
        chk("b2b0/const", 48'(got), 48'h11111111);
        access(1, 0, 0, 48'h4, 32'h0, LAT + 1, "b2b1", got); idle();
        chk("b2b1/const", 48'(got), 48'h22222222);

        // RAM range boundaries
        access(1, 0, 0, 48'h10000, 32'h0, LAT, "r_oob", got); idle();
        access(1, 0, 0, 48'h0, 32'h0, LAT, "r0_after_oob", got); idle();
        access(0, 1, 0, 48'(RAM_BYTES - 4), 32'hA5A55A5A, LAT, "w_last", got); idle();
        access(1, 0, 0, 48'(RAM_BYTES - 4), 32'h0, LAT, "r_last", got); idle();
        access(0, 1, 0, 48'(RAM_BYTES), 32'h0BADF00D, LAT, "w_first_oob", got); idle();
        access(1, 0, 0, 48'h800000000000, 32'h0, LAT, "r_top_bit", got); idle();
        access(1, 0, 0, 48'h3, 32'h0, LAT, "r_byte_ofs", got); idle();

        // Device bank
        access(1, 0, 1, 48'h0, 32'h0, LAT, "dev_id", got); idle();
        chk("dev_id/const", 48'(got), 48'(DEV_ID));
        access(0, 1, 1, 48'h4, 32'h1234, LAT, "dev_w_scr", got); idle();
        access(1, 0, 1, 48'h4, 32'h0, LAT, "dev_r_scr", got); idle();
        chk("dev_r_scr/const", 48'(got), 48'h1234);
        access(0, 1, 1, 48'h0, 32'hFFFF, LAT, "dev_w_id", got); idle();
        access(1, 0, 1, 48'h0, 32'h0, LAT, "dev_id2", got); idle();
        access(1, 0, 1, 48'h8, 32'h0, LAT, "dev_cyc1", v1); idle();
        access(1, 0, 1, 48'h8, 32'h0, LAT, "dev_cyc2", got); idle();
        chk("dev_cyc/increasing", 48'(got > v1), 48'd1);
        access(1, 0, 1, 48'h10, 32'h0, LAT, "dev_oob", got); idle();
        access(1, 0, 1, 48'hC, 32'h0, LAT, "dev_c1", got); idle();
        access(0, 1, 1, 48'hC, 32'h77, LAT, "dev_wc", got); idle();
        access(1, 0, 1, 48'hC, 32'h0, LAT, "dev_c2", got); idle();

        // Read and write together
        access(1, 1, 0, 48'h0, 32'h55, LAT, "both", got); idle();
        access(1, 0, 0, 48'h0, 32'h0, LAT, "r0_after_both", got); idle();
        chk("r0_after_both/const", 48'(got), 48'h11111111);

        // Randomized mix, including back-to-back requests
        last_acc = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic r, w, d;
            logic [47:0] a;
            int k, lat;
            k = $urandom_range(0, 9);
            r = (k < 5) || (k == 9);
            w = (k >= 5);
            d = ($urandom_range(0, 3) == 0);
            if (d)
                a = ($urandom_range(0, 9) == 0) ? 48'h10 + 48'($urandom_range(0, 255))
                                                 : 48'($urandom_range(0, 15));
            else
                a = ($urandom_range(0, 7) == 0) ? 48'(RAM_BYTES) + 48'($urandom_range(0, 65535))
                                                 : 48'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if (last_acc && $urandom_range(0, 1) == 1) begin
                lat = LAT + 1;
            end else begin
                if (last_acc) idle();
                lat = LAT;
            end
            access(r, w, d, a, $urandom, lat, "rand", got);
            last_acc = 1'b1;
        end
        idle();

        // Reset while a write is waiting
        access(0, 1, 0, 48'h8, 32'hABCD0123, LAT, "w8", got); idle();
        access(0, 1, 1, 48'h4, 32'h77, LAT, "dev_w_scr2", got); idle();
        bus.address = 48'h8; bus.device_space = 1'b0;
        bus.mem_write = 1'b1; drv_en = 1'b1; drv_val = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_write = 1'b0; drv_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort/mem_valid", 48'(bus.mem_valid), 48'd0);
            chk("abort/bus_error", 48'(bus.bus_error), 48'd0);
        end
        rst_n = 1'b1;
        scratch_m = '0;
        acc_m = '0;
        access(1, 0, 0, 48'h8, 32'h0, LAT, "r8_after_abort", got); idle();
        chk("r8_after_abort/const", 48'(got), 48'hABCD0123);
        access(1, 0, 1, 48'hC, 32'h0, LAT, "dev_c_after_rst", got); idle();
        access(1, 0, 1, 48'h4, 32'h0, LAT, "dev_scr_after_rst", got); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
